// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute-to-writeback path.
package alu_pkg;

    localparam logic [2:0]  ALU_CTR_MOD         = 3'b111;
    localparam int unsigned MOD_TIMEOUT_DEFAULT = 40;

    typedef enum logic [1:0] {
        StIdle,
        StModStart,
        StModWait,
        StWrite
    } seq_state_e;

endpackage

// File: rtl/mod_watchdog.sv
// Cycle counter bounding how long the sequencer waits on the mod unit.
module mod_watchdog
    import alu_pkg::*;
#(
    parameter int unsigned MOD_TIMEOUT = MOD_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned     CntW    = (MOD_TIMEOUT > 1) ? $clog2(MOD_TIMEOUT) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(MOD_TIMEOUT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == LastCnt);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            // Hold at the last value so the counter never wraps back to zero.
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_wb_sequencer.sv
// Registers ALU results into register-file write strobes and sequences
// multi-cycle mod operations with a watchdog-protected wait.
module alu_wb_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned RADDR_W     = 5,
    parameter int unsigned MOD_TIMEOUT = MOD_TIMEOUT_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               issue_valid,
    input  logic [2:0]         alu_ctr,
    input  logic               reg_write,
    input  logic [RADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               mod_done,
    output logic               mod_reset,
    output logic               stall,
    output logic               wb_en,
    output logic [RADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0]  wb_data,
    output logic               busy,
    output logic               timeout_err
);

    seq_state_e         state_q, state_d;
    logic [RADDR_W-1:0] rd_q, rd_d;
    logic               we_q, we_d;
    logic               wb_en_q, wb_en_d;
    logic [RADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0]  wb_data_q, wb_data_d;
    logic               terr_q, terr_d;
    logic               expired;

    mod_watchdog #(
        .MOD_TIMEOUT (MOD_TIMEOUT)
    ) u_mod_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q == StModStart),
        .enable  (state_q == StModWait),
        .expired (expired)
    );

    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        we_d      = we_q;
        wb_en_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        terr_d    = terr_q;
        unique case (state_q)
            StIdle: begin
                if (issue_valid) begin
                    if (alu_ctr == ALU_CTR_MOD) begin
                        rd_d    = rd_addr;
                        we_d    = reg_write;
                        state_d = StModStart;
                    end else begin
                        wb_en_d   = reg_write & (rd_addr != '0);
                        wb_addr_d = rd_addr;
                        wb_data_d = alu_result;
                    end
                end
            end
            StModStart: state_d = StModWait;
            StModWait: begin
                // A completion on the final watchdog cycle takes priority.
                if (mod_done) begin
                    wb_en_d   = we_q & (rd_q != '0);
                    wb_addr_d = rd_q;
                    wb_data_d = alu_result;
                    state_d   = StWrite;
                end else if (expired) begin
                    wb_en_d   = we_q & (rd_q != '0);
                    wb_addr_d = rd_q;
                    wb_data_d = '0;
                    terr_d    = 1'b1;
                    state_d   = StWrite;
                end
            end
            StWrite: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            rd_q      <= '0;
            we_q      <= 1'b0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            we_q      <= we_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            terr_q    <= terr_d;
        end
    end

    assign stall       = (state_q == StModStart) || (state_q == StModWait);
    assign mod_reset   = (state_q == StModStart);
    assign busy        = (state_q != StIdle);
    assign wb_en       = wb_en_q;
    assign wb_addr     = wb_addr_q;
    assign wb_data     = wb_data_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_alu_wb_sequencer.sv
// Scoreboard bench: instance 0 uses the default watchdog, instance 1 a short one.
module tb_alu_wb_sequencer;

    localparam int unsigned TO_A   = 40;
    localparam int unsigned TO_B   = 8;
    localparam logic [2:0]  OP_ADD = 3'b010;
    localparam logic [2:0]  OP_MOD = 3'b111;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  issue_v;
    logic [2:0]  alu_ctr;
    logic        reg_write;
    logic [4:0]  rd_addr;
    logic [31:0] alu_result;
    logic        mod_done;

    logic        mod_rst [2];
    logic        stall   [2];
    logic        wb_en   [2];
    logic [4:0]  wb_addr [2];
    logic [31:0] wb_data [2];
    logic        busy    [2];
    logic        terr    [2];

    int n_vec = 0;
    int n_err = 0;
    int stall_cnt [2] = '{0, 0};
    int mrst_cnt  [2] = '{0, 0};
    bit exp_terr  [2] = '{0, 0};
    logic [36:0] sb_q0 [$];
    logic [36:0] sb_q1 [$];

    always #5 clk = ~clk;

    alu_wb_sequencer dut_a (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_v[0]),
        .alu_ctr     (alu_ctr),
        .reg_write   (reg_write),
        .rd_addr     (rd_addr),
        .alu_result  (alu_result),
        .mod_done    (mod_done),
        .mod_reset   (mod_rst[0]),
        .stall       (stall[0]),
        .wb_en       (wb_en[0]),
        .wb_addr     (wb_addr[0]),
        .wb_data     (wb_data[0]),
        .busy        (busy[0]),
        .timeout_err (terr[0])
    );

    alu_wb_sequencer #(
        .MOD_TIMEOUT (TO_B)
    ) dut_b (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_v[1]),
        .alu_ctr     (alu_ctr),
        .reg_write   (reg_write),
        .rd_addr     (rd_addr),
        .alu_result  (alu_result),
        .mod_done    (mod_done),
        .mod_reset   (mod_rst[1]),
        .stall       (stall[1]),
        .wb_en       (wb_en[1]),
        .wb_addr     (wb_addr[1]),
        .wb_data     (wb_data[1]),
        .busy        (busy[1]),
        .timeout_err (terr[1])
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write-port monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        logic [36:0] e;
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                if (stall[i])   stall_cnt[i]++;
                if (mod_rst[i]) mrst_cnt[i]++;
            end
            if (wb_en[0]) begin
                check_eq("wb_stall_a", 64'(stall[0]), 64'd0);
                if (sb_q0.size() == 0) begin
                    check_eq("wb_spurious_a", 64'(wb_en[0]), 64'd0);
                end else begin
                    e = sb_q0.pop_front();
                    check_eq("wb_a", 64'({wb_addr[0], wb_data[0]}), 64'(e));
                end
            end
            if (wb_en[1]) begin
                check_eq("wb_stall_b", 64'(stall[1]), 64'd0);
                if (sb_q1.size() == 0) begin
                    check_eq("wb_spurious_b", 64'(wb_en[1]), 64'd0);
                end else begin
                    e = sb_q1.pop_front();
                    check_eq("wb_b", 64'({wb_addr[1], wb_data[1]}), 64'(e));
                end
            end
        end
    end

    // done_after: cycles after the mod_reset cycle at which mod_done pulses (0 = never).
    task automatic run_op(input int inst, input logic [2:0] ctr, input logic [4:0] rd,
                          input logic we, input logic [31:0] res, input int done_after,
                          input bit hold);
        int  to_lim;
        int  end_c;
        int  s0;
        int  m0;
        bit  is_mod;
        bit  tmo;
        to_lim = (inst == 0) ? TO_A : TO_B;
        is_mod = (ctr == OP_MOD);
        tmo    = 1'b0;
        end_c  = 1;
        if (is_mod) begin
            tmo   = (done_after == 0) || (done_after > to_lim);
            end_c = tmo ? to_lim + 2 : done_after + 2;
        end
        if (we && rd != 5'd0) begin
            if (inst == 0) sb_q0.push_back({rd, (tmo ? 32'd0 : res)});
            else           sb_q1.push_back({rd, (tmo ? 32'd0 : res)});
        end
        if (tmo) exp_terr[inst] = 1'b1;
        s0 = stall_cnt[inst];
        m0 = mrst_cnt[inst];

        @(posedge clk); #1;
        issue_v[inst] = 1'b1;
        alu_ctr       = ctr;
        rd_addr       = rd;
        reg_write     = we;
        alu_result    = is_mod ? 32'hdead_beef : res;
        for (int c = 1; c <= end_c; c++) begin
            @(posedge clk); #1;
            if (!hold) issue_v[inst] = 1'b0;
            mod_done   = (done_after != 0) && (c == done_after + 1);
            alu_result = mod_done ? res : 32'hdead_beef;
        end
        @(posedge clk); #1;
        issue_v[inst] = 1'b0;
        mod_done      = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); #1;

        check_eq("stall_cycles", 64'(stall_cnt[inst] - s0), 64'(is_mod ? end_c - 1 : 0));
        check_eq("mod_reset_pulses", 64'(mrst_cnt[inst] - m0), 64'(is_mod ? 1 : 0));
        check_eq("busy_after", 64'(busy[inst]), 64'd0);
        check_eq("timeout_err", 64'(terr[inst]), 64'(exp_terr[inst]));
        check_eq("sb_drained", 64'(inst == 0 ? sb_q0.size() : sb_q1.size()), 64'd0);
    endtask

    initial begin
        reset      = 1'b1;
        issue_v    = 2'b00;
        alu_ctr    = 3'd0;
        reg_write  = 1'b0;
        rd_addr    = 5'd0;
        alu_result = 32'd0;
        mod_done   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_wb_en", 64'(wb_en[0]), 64'd0);
        check_eq("rst_wb_addr", 64'(wb_addr[0]), 64'd0);
        check_eq("rst_wb_data", 64'(wb_data[0]), 64'd0);
        check_eq("rst_stall", 64'(stall[0]), 64'd0);
        check_eq("rst_mod_reset", 64'(mod_rst[0]), 64'd0);
        check_eq("rst_busy", 64'(busy[0]), 64'd0);
        check_eq("rst_timeout_err", 64'(terr[1]), 64'd0);
        reset = 1'b0;

        run_op(0, OP_ADD, 5'd3, 1'b1, 32'h0000_0005, 0, 1'b0);
        run_op(0, OP_MOD, 5'd7, 1'b1, 32'h0000_0002, 10, 1'b1);
        run_op(0, OP_ADD, 5'd0, 1'b1, 32'h0000_1234, 0, 1'b0);
        run_op(0, OP_MOD, 5'd0, 1'b1, 32'h0000_0009, 5, 1'b0);
        run_op(0, OP_ADD, 5'd12, 1'b0, 32'h0000_0abc, 0, 1'b0);
        run_op(0, OP_MOD, 5'd31, 1'b1, 32'h8000_0001, 1, 1'b1);
        run_op(1, OP_MOD, 5'd4, 1'b1, 32'h0000_cafe, TO_B, 1'b1);
        run_op(1, OP_MOD, 5'd5, 1'b1, 32'h0000_0077, 0, 1'b0);
        run_op(1, OP_ADD, 5'd6, 1'b1, 32'h0000_0055, 0, 1'b0);

        // Reset during the third MOD_WAIT cycle drops the pending write.
        @(posedge clk); #1;
        issue_v[0] = 1'b1;
        alu_ctr    = OP_MOD;
        rd_addr    = 5'd9;
        reg_write  = 1'b1;
        alu_result = 32'hdead_beef;
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("midop_busy", 64'(busy[0]), 64'd1);
        check_eq("midop_stall", 64'(stall[0]), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("midrst_outs", 64'({wb_en[0], wb_addr[0], wb_data[0], stall[0], mod_rst[0],
                                     busy[0], terr[0]}), 64'd0);
        check_eq("midrst_terr_b", 64'(terr[1]), 64'd0);
        reset      = 1'b0;
        issue_v[0] = 1'b0;
        exp_terr   = '{0, 0};

        run_op(0, OP_ADD, 5'd10, 1'b1, 32'h0000_0abc, 0, 1'b0);
        run_op(1, OP_ADD, 5'd11, 1'b1, 32'h1357_9bdf, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
